exmm_skid_buf: RTL and testbench

- Parametrised, elastic successor to the fixed EX/MEM pipeline register.
- Carries control bits, data words and register indices from EX to MEM using a valid/ready handshake.
- A 2-entry skid (main plus skid register) lets upstream stall on a registered ready, so there is no combinational ready path.
- Adds flush, bubble zeroing and a sticky halt latch.

---
 rtl/exmm_skid_buf_pkg.sv | 24 ++
 rtl/exmm_skid_buf_if.sv | 41 ++++
 rtl/exmm_skid_buf_entry_reg.sv | 31 +++
 rtl/exmm_skid_buf.sv | 172 +++++++++++++++++
 tb/tb_exmm_skid_buf.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/exmm_skid_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared EX/MEM pipeline definitions. Holds the occupancy
//               state encoding and the default control-bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Buffer occupancy: main entry only (ONE) or main plus skid (FULL)
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Default bit positions inside the control vector
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEM2REG  = 2;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 0;

endpackage
`default_nettype wire

// File: rtl/exmm_skid_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : exmm_skid_buf_if
// Description : EX/MEM handshake bundle. The upstream valid/ready pair and
//               payload, plus the downstream valid/ready pair and payload.
//               master = pipeline stages around the buffer, slave = buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface exmm_skid_buf_if #(
    parameter int DATA_W = 32,
    parameter int NDATA  = 2,
    parameter int REG_W  = 5,
    parameter int NREG   = 2,
    parameter int CTRL_W = 4
) ();
    // Upstream (EX side)
    logic                    inValid;
    logic                    inReady;
    logic                    haltIn;
    logic [CTRL_W-1:0]       ctrlIn;
    logic [NDATA*DATA_W-1:0] dataIn;
    logic [NREG*REG_W-1:0]   regIn;
    // Downstream (MEM side)
    logic                    outValid;
    logic                    outReady;
    logic                    haltOut;
    logic [CTRL_W-1:0]       ctrlOut;
    logic [NDATA*DATA_W-1:0] dataOut;
    logic [NREG*REG_W-1:0]   regOut;

    modport master (
        output inValid, haltIn, ctrlIn, dataIn, regIn, outReady,
        input  inReady, outValid, haltOut, ctrlOut, dataOut, regOut
    );

    modport slave (
        input  inValid, haltIn, ctrlIn, dataIn, regIn, outReady,
        output inReady, outValid, haltOut, ctrlOut, dataOut, regOut
    );
endinterface
`default_nettype wire

// File: rtl/exmm_skid_buf_entry_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_entry_reg
// Description : One buffered pipeline payload. Clear wins over load so a
//               slot that goes invalid always reads back as all zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_entry_reg #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_clear,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    // Zero on reset/clear, capture on load, otherwise hold
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule
`default_nettype wire

// File: rtl/exmm_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : exmm_skid_buf
// Description : Elastic EX/MEM pipeline register. Two-entry skid buffer
//               (main + skid) with registered inReady, flush, bubble
//               zeroing and a sticky halt latch.
//               Optional: define EXMM_STALL_CNT_EN to build the saturating
//               32-bit stallCount; otherwise stallCount is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module exmm_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NDATA  = 2,
    parameter int REG_W  = 5,
    parameter int NREG   = 2,
    parameter int CTRL_W = 4
) (
    input  wire logic        clockIn,
    input  wire logic        reset,
    input  wire logic        flush,
    exmm_skid_buf_if.slave   bus,
    output logic             halted,
    output logic [31:0]      stallCount
);
    localparam int c_DW = NDATA * DATA_W;
    localparam int c_RW = NREG * REG_W;
    localparam int c_PW = 1 + CTRL_W + c_DW + c_RW;

    state_e            r_state;
    state_e            w_nextState;
    logic              r_inReady;
    logic              r_outValid;
    logic              r_halted;
    logic              w_nextHalted;
    logic              w_push;
    logic              w_pop;
    logic              w_mainLoad;
    logic              w_mainClear;
    logic              w_mainFromSkid;
    logic              w_skidLoad;
    logic              w_skidClear;
    logic [c_PW-1:0]   w_inPayload;
    logic [c_PW-1:0]   w_mainD;
    logic [c_PW-1:0]   w_mainQ;
    logic [c_PW-1:0]   w_skidQ;

    assign w_push      = bus.inValid & r_inReady;
    assign w_pop       = r_outValid & bus.outReady;
    assign w_inPayload = {bus.haltIn, bus.ctrlIn, bus.dataIn, bus.regIn};

    // Next occupancy and per-slot load/clear decisions
    always_comb begin
        w_nextState    = r_state;
        w_mainLoad     = 1'b0;
        w_mainClear    = 1'b0;
        w_mainFromSkid = 1'b0;
        w_skidLoad     = 1'b0;
        w_skidClear    = 1'b0;
        if (flush) begin
            w_nextState = EMPTY;
            w_mainClear = 1'b1;
            w_skidClear = 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_nextState = ONE;
                        w_mainLoad  = 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && !w_pop) begin
                        w_nextState = FULL;
                        w_skidLoad  = 1'b1;
                    end else if (w_push && w_pop) begin
                        w_mainLoad  = 1'b1;
                    end else if (w_pop) begin
                        w_nextState = EMPTY;
                        w_mainClear = 1'b1;
                    end
                end
                FULL: begin
                    // inReady is low here, so only the skid can move up
                    if (w_pop) begin
                        w_nextState    = ONE;
                        w_mainLoad     = 1'b1;
                        w_mainFromSkid = 1'b1;
                        w_skidClear    = 1'b1;
                    end
                end
                default: begin
                    w_nextState = EMPTY;
                    w_mainClear = 1'b1;
                    w_skidClear = 1'b1;
                end
            endcase
        end
    end

    assign w_nextHalted = flush ? 1'b0 : (r_halted | (w_push & bus.haltIn));
    assign w_mainD      = w_mainFromSkid ? w_skidQ : w_inPayload;

    // State register with registered ready/valid/halt flags
    always_ff @(posedge clockIn) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_inReady  <= (w_nextState != FULL) && !w_nextHalted;
            r_outValid <= (w_nextState != EMPTY);
            r_halted   <= w_nextHalted;
        end
    end

    pipe_entry_reg #(.WIDTH(c_PW)) u_main (
        .clk     (clockIn),
        .rst     (reset),
        .i_load  (w_mainLoad),
        .i_clear (w_mainClear),
        .i_d     (w_mainD),
        .o_q     (w_mainQ)
    );

    pipe_entry_reg #(.WIDTH(c_PW)) u_skid (
        .clk     (clockIn),
        .rst     (reset),
        .i_load  (w_skidLoad),
        .i_clear (w_skidClear),
        .i_d     (w_inPayload),
        .o_q     (w_skidQ)
    );

    assign bus.inReady  = r_inReady;
    assign bus.outValid = r_outValid;
    assign bus.haltOut  = w_mainQ[c_PW-1];
    assign bus.ctrlOut  = w_mainQ[c_DW+c_RW +: CTRL_W];
    assign bus.dataOut  = w_mainQ[c_RW +: c_DW];
    assign bus.regOut   = w_mainQ[0 +: c_RW];
    assign halted       = r_halted;

`ifdef EXMM_STALL_CNT_EN
    logic [31:0] r_stallCount;

    // Saturating count of cycles where MEM holds off a valid entry
    always_ff @(posedge clockIn) begin
        if (reset) begin
            r_stallCount <= 32'd0;
        end else if (r_outValid && !bus.outReady && (r_stallCount != 32'hFFFF_FFFF)) begin
            r_stallCount <= r_stallCount + 32'd1;
        end
    end

    assign stallCount = r_stallCount;
`else
    assign stallCount = 32'd0;
`endif

    // The skid must never be able to overflow
    a_fullNotReady: assert property (@(posedge clockIn) disable iff (reset)
        !((r_state == FULL) && r_inReady));

    // A stalled entry may only leave through flush
    a_noDrop: assert property (@(posedge clockIn) disable iff (reset)
        (r_outValid && !bus.outReady && !flush) |=> r_outValid);

endmodule
`default_nettype wire

// File: tb/tb_exmm_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_exmm_skid_buf
// Description : Directed self-checking bench for exmm_skid_buf with a
//               payload scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exmm_skid_buf;
    localparam int c_PW = 1 + 4 + 64 + 10;
    typedef logic [c_PW-1:0] pl_t;

    logic        clockIn = 1'b0;
    logic        reset;
    logic        flush;
    logic        halted;
    logic [31:0] stallCount;
    int          checks = 0;
    int          errors = 0;
    pl_t         sb[$];

`ifdef EXMM_STALL_CNT_EN
    localparam logic [31:0] c_STALL7 = 32'd7;
`else
    localparam logic [31:0] c_STALL7 = 32'd0;
`endif

    exmm_skid_buf_if bus ();

    exmm_skid_buf dut (
        .clockIn    (clockIn),
        .reset      (reset),
        .flush      (flush),
        .bus        (bus.slave),
        .halted     (halted),
        .stallCount (stallCount)
    );

    always #5 clockIn = ~clockIn;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic h, input logic [31:0] w0);
        bus.inValid = v;
        bus.haltIn  = h;
        bus.ctrlIn  = {1'b1, w0[2:0]};
        bus.dataIn  = {~w0, w0};
        bus.regIn   = {w0[4:0], ~w0[4:0]};
    endtask

    // One clock: scoreboard bookkeeping at negedge, then step past posedge
    task automatic cycle();
        pl_t exp_pl;
        @(negedge clockIn);
        if (reset) begin
            sb.delete();
        end else begin
            if (bus.outValid && bus.outReady) begin
                check("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    exp_pl = sb.pop_front();
                    check("pop_payload", {bus.haltOut, bus.ctrlOut, bus.dataOut, bus.regOut}, exp_pl);
                end
            end
            if (flush) sb.delete();
            else if (bus.inValid && bus.inReady)
                sb.push_back({bus.haltIn, bus.ctrlIn, bus.dataIn, bus.regIn});
        end
        @(posedge clockIn);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        bus.outReady = 1'b0;
        drive(1'b0, 1'b0, 32'h0);

        // Reset
        cycle(); cycle();
        check("rst_outValid", bus.outValid, 1'b0);
        check("rst_inReady", bus.inReady, 1'b1);
        check("rst_ctrlOut", bus.ctrlOut, 4'h0);
        check("rst_halted", halted, 1'b0);
        check("rst_stallCount", stallCount, 32'd0);
        reset = 1'b0;

        // Streaming back-to-back
        bus.outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h11 * (i + 1));
            cycle();
            check("stream_valid", bus.outValid, 1'b1);
            check("stream_word0", bus.dataOut[31:0], 32'h11 * (i + 1));
            check("stream_inReady", bus.inReady, 1'b1);
        end
        drive(1'b0, 1'b0, 32'h0);
        cycle();
        check("stream_drain_valid", bus.outValid, 1'b0);
        check("stream_bubble_data", bus.dataOut, 64'h0);
        check("stream_bubble_ctrl", bus.ctrlOut, 4'h0);

        // Skid absorbs one entry after downstream stalls
        drive(1'b1, 1'b0, 32'hA0);
        cycle();
        check("skid_A0_out", bus.dataOut[31:0], 32'hA0);
        bus.outReady = 1'b0;
        drive(1'b1, 1'b0, 32'hA1);
        cycle();
        check("skid_full_inReady", bus.inReady, 1'b0);
        check("skid_hold_A0", bus.dataOut[31:0], 32'hA0);
        drive(1'b1, 1'b0, 32'hA2);
        cycle();
        check("skid_hold2_A0", bus.dataOut[31:0], 32'hA0);
        check("skid_hold2_valid", bus.outValid, 1'b1);
        check("skid_hold2_inReady", bus.inReady, 1'b0);
        drive(1'b0, 1'b0, 32'h0);
        bus.outReady = 1'b1;
        cycle();
        check("skid_A1_out", bus.dataOut[31:0], 32'hA1);
        check("skid_ready_back", bus.inReady, 1'b1);
        cycle();
        check("skid_empty", bus.outValid, 1'b0);

        // Flush while FULL with an offered entry
        bus.outReady = 1'b0;
        drive(1'b1, 1'b0, 32'hC0); cycle();
        drive(1'b1, 1'b0, 32'hC1); cycle();
        check("flush_pre_full", bus.inReady, 1'b0);
        flush = 1'b1;
        drive(1'b1, 1'b0, 32'hBB);
        cycle();
        flush = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        check("flush_valid", bus.outValid, 1'b0);
        check("flush_ctrl", bus.ctrlOut, 4'h0);
        check("flush_data", bus.dataOut, 64'h0);
        check("flush_inReady", bus.inReady, 1'b1);
        bus.outReady = 1'b1;
        cycle();
        check("flush_stays_empty", bus.outValid, 1'b0);

        // Flush in ONE discards a simultaneous push
        bus.outReady = 1'b0;
        drive(1'b1, 1'b0, 32'hD0); cycle();
        flush = 1'b1;
        drive(1'b1, 1'b0, 32'hBE);
        cycle();
        flush = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        check("flush1_valid", bus.outValid, 1'b0);
        check("flush1_data", bus.dataOut, 64'h0);
        bus.outReady = 1'b1;
        cycle();
        check("flush1_stays_empty", bus.outValid, 1'b0);

        // Halt latch
        bus.outReady = 1'b0;
        drive(1'b1, 1'b1, 32'h55);
        cycle();
        check("halt_set", halted, 1'b1);
        check("halt_inReady", bus.inReady, 1'b0);
        check("halt_haltOut", bus.haltOut, 1'b1);
        check("halt_word0", bus.dataOut[31:0], 32'h55);
        drive(1'b1, 1'b0, 32'h66);
        cycle(); cycle();
        check("halt_hold_word0", bus.dataOut[31:0], 32'h55);
        bus.outReady = 1'b1;
        cycle();
        check("halt_drained", bus.outValid, 1'b0);
        check("halt_haltOut_clr", bus.haltOut, 1'b0);
        check("halt_sticky", halted, 1'b1);
        check("halt_inReady_low", bus.inReady, 1'b0);
        cycle();
        check("halt_ignored_push", bus.outValid, 1'b0);
        drive(1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("halt_flush_clr", halted, 1'b0);
        check("halt_flush_ready", bus.inReady, 1'b1);

        // Stall counter
        reset = 1'b1;
        bus.outReady = 1'b0;
        cycle(); cycle();
        reset = 1'b0;
        check("stall_rst", stallCount, 32'd0);
        drive(1'b1, 1'b0, 32'h77);
        cycle();
        drive(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) cycle();
        check("stall_count7", stallCount, c_STALL7);
        bus.outReady = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("stall_after_flush", stallCount, c_STALL7);
        check("stall_flush_valid", bus.outValid, 1'b0);
        cycle();
        check("stall_idle", stallCount, c_STALL7);

        check("sb_empty_end", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
